// File: rtl/interp_bracket_search_pkg.sv
// Shared widths and FSM encoding for the bracket search, the sample BRAMs and linearinterpolate.
package interp_bracket_search_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/interp_bracket_search.sv
// Linear scan of the sorted x/y sample BRAMs for the first x[i] >= x_find; returns the bracketing
// pair (x[i-1],y[i-1]),(x[i],y[i]) with clamp flags at either end of the table.
module interp_bracket_search
  import interp_bracket_search_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x_find,
  input  logic [ADDR_W:0]   num_points,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] x_rdata,
  input  logic [DATA_W-1:0] y_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y1,
  output logic              clamp_lo,
  output logic              clamp_hi,
  output logic              err
);

  localparam int WAIT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_x_find;
  logic [ADDR_W:0]     r_num;
  logic [ADDR_W:0]     r_idx;
  logic [WAIT_W-1:0]   r_wait;
  logic [DATA_W-1:0]   r_prev_x, r_prev_y;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_busy, r_done, r_clamp_lo, r_clamp_hi, r_err;
  logic [DATA_W-1:0]   r_x0, r_y0, r_x1, r_y1;

  logic                w_hit;
  logic                w_last;
  logic [ADDR_W:0]     w_idx_next;

  assign w_hit      = (x_rdata >= r_x_find);
  assign w_last     = (r_idx == (r_num - IDX_ONE));
  assign w_idx_next = r_idx + IDX_ONE;

  // NOTE: all state here is updated with <= so every branch sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_x_find   <= '0;
      r_num      <= '0;
      r_idx      <= '0;
      r_wait     <= '0;
      r_prev_x   <= '0;
      r_prev_y   <= '0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clamp_lo <= 1'b0;
      r_clamp_hi <= 1'b0;
      r_err      <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x_find   <= x_find;
            r_num      <= num_points;
            r_idx      <= '0;
            r_rd_addr  <= '0;
            r_clamp_lo <= 1'b0;
            r_clamp_hi <= 1'b0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            if (num_points == '0) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_wait  <= WAIT_W'(RD_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_CMP;
          else              r_wait  <= r_wait - 1'b1;
        end
        S_CMP: begin
          if (w_hit || w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
            r_x1    <= x_rdata;
            r_y1    <= y_rdata;
            // A hit past index 0 brackets with the previous sample; every other exit is a clamp.
            if (w_hit && r_idx != '0) begin
              r_x0 <= r_prev_x;
              r_y0 <= r_prev_y;
            end else begin
              r_x0       <= x_rdata;
              r_y0       <= y_rdata;
              r_clamp_lo <= w_hit;
              r_clamp_hi <= !w_hit;
            end
          end else begin
            r_prev_x  <= x_rdata;
            r_prev_y  <= y_rdata;
            r_idx     <= w_idx_next;
            r_rd_addr <= w_idx_next[ADDR_W-1:0];
            r_state   <= S_ISSUE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr  = r_rd_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign x0       = r_x0;
  assign y0       = r_y0;
  assign x1       = r_x1;
  assign y1       = r_y1;
  assign clamp_lo = r_clamp_lo;
  assign clamp_hi = r_clamp_hi;
  assign err      = r_err;

endmodule

// File: tb/tb_interp_bracket_search.sv
// Bench for interp_bracket_search: two instances (RD_LAT 1 and 3) on modelled BRAMs, scoreboarded results.
module tb_interp_bracket_search;

  typedef struct {
    int xf;
    int n;
    int x0, y0, x1, y1;
    bit lo, hi, er;
    int k;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_s    [2];
  logic [15:0] x_find_s   [2];
  logic [10:0] num_s      [2];
  logic [9:0]  rd_addr_s  [2];
  logic [15:0] x_rdata_s  [2];
  logic [15:0] y_rdata_s  [2];
  logic        busy_s     [2];
  logic        done_s     [2];
  logic [15:0] x0_s [2], y0_s [2], x1_s [2], y1_s [2];
  logic        lo_s [2], hi_s [2], err_s [2];

  logic [15:0] xm [1024];
  logic [15:0] ym [1024];
  logic [9:0]  ap0;
  logic [9:0]  ap1 [3];

  vec_t vecs [9];
  vec_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  interp_bracket_search #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .x_find(x_find_s[0]), .num_points(num_s[0]),
    .rd_addr(rd_addr_s[0]), .x_rdata(x_rdata_s[0]), .y_rdata(y_rdata_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .x0(x0_s[0]), .y0(y0_s[0]), .x1(x1_s[0]), .y1(y1_s[0]),
    .clamp_lo(lo_s[0]), .clamp_hi(hi_s[0]), .err(err_s[0])
  );

  interp_bracket_search #(.ADDR_W(10), .DATA_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .x_find(x_find_s[1]), .num_points(num_s[1]),
    .rd_addr(rd_addr_s[1]), .x_rdata(x_rdata_s[1]), .y_rdata(y_rdata_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .x0(x0_s[1]), .y0(y0_s[1]), .x1(x1_s[1]), .y1(y1_s[1]),
    .clamp_lo(lo_s[1]), .clamp_hi(hi_s[1]), .err(err_s[1])
  );

  // BRAM models: read data follows the address by RD_LAT clock edges.
  always @(posedge clk) begin
    ap0    <= rd_addr_s[0];
    ap1[0] <= rd_addr_s[1];
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end
  assign x_rdata_s[0] = xm[ap0];
  assign y_rdata_s[0] = ym[ap0];
  assign x_rdata_s[1] = xm[ap1[2]];
  assign y_rdata_s[1] = ym[ap1[2]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] flags(input int lane);
    return 32'({busy_s[lane], done_s[lane], lo_s[lane], hi_s[lane], err_s[lane]});
  endfunction

  task automatic check_cleared(input int lane, input string tag);
    check($sformatf("L%0d %s flags", lane, tag), flags(lane), 32'd0);
    check($sformatf("L%0d %s rd_addr", lane, tag), 32'(rd_addr_s[lane]), 32'd0);
    check($sformatf("L%0d %s x0y0", lane, tag), {x0_s[lane], y0_s[lane]}, 32'd0);
    check($sformatf("L%0d %s x1y1", lane, tag), {x1_s[lane], y1_s[lane]}, 32'd0);
  endtask

  task automatic run_search(input int lane, input vec_t v, input bit poke);
    vec_t e;
    int   lat, cyc, run, trans, badrun, exp_lat;
    bit   seen;
    logic [9:0] pa;
    lat = (lane == 0) ? 1 : 3;
    sb.push_back(v);
    @(negedge clk);
    start_s[lane]  = 1'b1;
    x_find_s[lane] = v.xf[15:0];
    num_s[lane]    = v.n[10:0];
    @(negedge clk);
    start_s[lane] = 1'b0;
    cyc = 1;
    if (!v.er) begin
      check($sformatf("L%0d x=%0d busy_on", lane, v.xf), 32'(busy_s[lane]), 32'd1);
      check($sformatf("L%0d x=%0d addr0", lane, v.xf), 32'(rd_addr_s[lane]), 32'd0);
    end
    pa = rd_addr_s[lane];
    run = 1; trans = 0; badrun = 0;
    seen = done_s[lane];
    while (!seen && cyc < 300) begin
      if (poke && (cyc == 2 || cyc == 5)) begin
        start_s[lane]  = 1'b1;
        x_find_s[lane] = 16'd45;
        num_s[lane]    = 11'd1;
      end else begin
        start_s[lane] = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (rd_addr_s[lane] != pa) begin
        trans++;
        if (run != lat + 2) badrun++;
        run = 1;
        pa  = rd_addr_s[lane];
      end else begin
        run++;
      end
      seen = done_s[lane];
    end
    start_s[lane] = 1'b0;
    if (!seen) check($sformatf("L%0d x=%0d done_timeout", lane, v.xf), 32'd0, 32'd1);
    e = sb.pop_front();
    exp_lat = e.er ? 1 : (lat + 2) * (e.k + 1) + 1;
    check($sformatf("L%0d x=%0d latency", lane, e.xf), cyc, exp_lat);
    check($sformatf("L%0d x=%0d x0", lane, e.xf), 32'(x0_s[lane]), e.x0);
    check($sformatf("L%0d x=%0d y0", lane, e.xf), 32'(y0_s[lane]), e.y0);
    check($sformatf("L%0d x=%0d x1", lane, e.xf), 32'(x1_s[lane]), e.x1);
    check($sformatf("L%0d x=%0d y1", lane, e.xf), 32'(y1_s[lane]), e.y1);
    check($sformatf("L%0d x=%0d flags", lane, e.xf), flags(lane),
          32'({1'b0, 1'b1, e.lo, e.hi, e.er}));
    if (!e.er) begin
      check($sformatf("L%0d x=%0d addr_steps", lane, e.xf), trans, e.k);
      check($sformatf("L%0d x=%0d addr_hold", lane, e.xf), badrun, 0);
    end
    @(negedge clk);
    check($sformatf("L%0d x=%0d done_pulse", lane, e.xf), 32'(done_s[lane]), 32'd0);
    check($sformatf("L%0d x=%0d held", lane, e.xf), {x1_s[lane], y1_s[lane]}, {e.x1[15:0], e.y1[15:0]});
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 1024; i++) begin
      xm[i] = 16'hFFFF;
      ym[i] = 16'hDEAD;
    end
    for (int i = 0; i < 5; i++) begin
      xm[i] = 16'(10 * i);
      ym[i] = 16'(100 * (i + 1));
    end
    //          xf  n   x0  y0   x1  y1   lo hi er k
    vecs[0] = '{25, 5, 20, 300, 30, 400, 0, 0, 0, 3};
    vecs[1] = '{ 0, 5,  0, 100,  0, 100, 1, 0, 0, 0};
    vecs[2] = '{40, 5, 30, 400, 40, 500, 0, 0, 0, 4};
    vecs[3] = '{45, 5, 40, 500, 40, 500, 0, 1, 0, 4};
    vecs[4] = '{25, 0,  0,   0,  0,   0, 0, 0, 1, 0};
    vecs[5] = '{ 5, 1,  0, 100,  0, 100, 0, 1, 0, 0};
    vecs[6] = '{10, 5,  0, 100, 10, 200, 0, 0, 0, 1};
    vecs[7] = '{15, 3, 10, 200, 20, 300, 0, 0, 0, 2};
    vecs[8] = '{11, 2, 10, 200, 10, 200, 0, 1, 0, 1};

    for (int l = 0; l < 2; l++) begin
      start_s[l] = 1'b0;
      x_find_s[l] = '0;
      num_s[l] = '0;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++) check_cleared(l, "reset");
    reset_n = 1'b1;

    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 9; i++) run_search(l, vecs[i], 1'b0);

    // Starts and key changes while busy must not disturb the running search.
    run_search(0, vecs[0], 1'b1);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      dn += 32'(done_s[0]);
    end
    check("L0 no_extra_done", dn, 0);

    // Reset in the middle of a search on both instances.
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      start_s[l] = 1'b1;
      x_find_s[l] = 16'd25;
      num_s[l] = 11'd5;
    end
    @(negedge clk);
    for (int l = 0; l < 2; l++) start_s[l] = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) check_cleared(l, "midreset");
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      dn += 32'(done_s[0]) + 32'(done_s[1]) + 32'(busy_s[0]) + 32'(busy_s[1]);
    end
    check("midreset no_restart", dn, 0);
    for (int l = 0; l < 2; l++) run_search(l, vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
